// File: rtl/fare_pkg.sv
// Shared definitions for the taxi-meter fare controller: controller state
// encoding and the saturated BCD fare value.
package fare_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [15:0] FARE_MAX = 16'h9999;

endpackage

// File: rtl/bcd_adder_4.sv
// Four-digit packed-BCD adder with carry-in and carry-out; purely combinational.
module bcd_adder_4 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [4:0] digit;
  logic       carry;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so the loop reads this-iteration values and no latch forms.
  always_comb begin
    carry = c_in;
    sum   = '0;
    digit = '0;
    for (int i = 0; i < 4; i++) begin
      digit = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
      if (digit > 5'd9) begin
        digit = digit + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[4*i +: 4] = digit[3:0];
    end
    c_out = carry;
  end

endmodule

// File: rtl/fare_accum_ctrl.sv
// Taxi-meter fare sequencer: arbitrates distance and waiting ticks onto one
// shared BCD adder. Optional night tariff is enabled with macro NIGHT_RATE_EN.
module fare_accum_ctrl
  import fare_pkg::*;
#(
  parameter logic [15:0] BASE_FARE     = 16'h0800,
  parameter logic [15:0] KM_RATE       = 16'h0200,
  parameter logic [15:0] WAIT_RATE     = 16'h0050,
  parameter logic [3:0]  FREE_KM       = 4'd3
`ifdef NIGHT_RATE_EN
  ,
  parameter logic [15:0] NIGHT_KM_RATE = 16'h0300
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        dist_tick,
  input  logic        wait_tick,
`ifdef NIGHT_RATE_EN
  input  logic        night,
`endif
  output logic [15:0] fare,
  output logic        running,
  output logic        sat,
  output logic        overrun
);

  state_t      state;
  logic [3:0]  km_cnt;
  logic        dist_pend;
  logic        wait_pend;

  logic        dist_grant;
  logic        wait_grant;
  logic        do_add;
  logic        tick_lost;
  logic [15:0] km_op;
  logic [15:0] add_b;
  logic [15:0] sum;
  logic        c_out;

  always_comb begin
`ifdef NIGHT_RATE_EN
    km_op = night ? NIGHT_KM_RATE : KM_RATE;
`else
    km_op = KM_RATE;
`endif
    dist_grant = (state == RUN) && dist_pend;
    wait_grant = (state == RUN) && wait_pend && !dist_pend;
    add_b      = dist_grant ? km_op : WAIT_RATE;
    // Free kilometres consume the request without touching the fare.
    do_add     = !sat && ((dist_grant && (km_cnt >= FREE_KM)) || wait_grant);
    tick_lost  = (dist_tick && dist_pend && !dist_grant) ||
                 (wait_tick && wait_pend && !wait_grant);
  end

  bcd_adder_4 u_adder (
    .a     (fare),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fare      <= '0;
      running   <= 1'b0;
      sat       <= 1'b0;
      overrun   <= 1'b0;
      km_cnt    <= '0;
      dist_pend <= 1'b0;
      wait_pend <= 1'b0;
    end else begin
      running <= (state == LOAD) || (state == RUN);
      unique case (state)
        IDLE: if (start) state <= LOAD;
        LOAD: begin
          fare      <= BASE_FARE;
          km_cnt    <= '0;
          dist_pend <= 1'b0;
          wait_pend <= 1'b0;
          sat       <= 1'b0;
          overrun   <= 1'b0;
          state     <= RUN;
        end
        RUN: begin
          if (dist_grant && (km_cnt != 4'hF)) km_cnt <= km_cnt + 4'd1;
          if (do_add) begin
            if (c_out) begin
              fare <= FARE_MAX;
              sat  <= 1'b1;
            end else begin
              fare <= sum;
            end
          end
          if (stop) begin
            // Ticks in the stop cycle and anything still pending are discarded.
            dist_pend <= 1'b0;
            wait_pend <= 1'b0;
            state     <= HOLD;
          end else begin
            dist_pend <= dist_tick || (dist_pend && !dist_grant);
            wait_pend <= wait_tick || (wait_pend && !wait_grant);
            if (tick_lost) overrun <= 1'b1;
          end
        end
        HOLD: if (start) state <= LOAD;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fare_accum_ctrl.sv
// Scoreboard bench for fare_accum_ctrl: a cents-based trip model predicts every
// cycle's outputs; a negedge monitor compares them against the DUT.
module tb_fare_accum_ctrl;

  localparam int BASE_C  = 800;
  localparam int KM_C    = 200;
  localparam int WAIT_C  = 50;
  localparam int NIGHT_C = 300;
  localparam int FREE_C  = 3;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        dist_tick = 1'b0;
  logic        wait_tick = 1'b0;
`ifdef NIGHT_RATE_EN
  logic        night = 1'b0;
`endif
  logic [15:0] fare;
  logic        running;
  logic        sat;
  logic        overrun;

  fare_accum_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .dist_tick (dist_tick),
    .wait_tick (wait_tick),
`ifdef NIGHT_RATE_EN
    .night     (night),
`endif
    .fare      (fare),
    .running   (running),
    .sat       (sat),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] fare;
    logic        running;
    logic        sat;
    logic        overrun;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   hold_rst = 1'b1;
  bit   night_v = 1'b0;

  // Trip model, fare kept in cents.
  int m_st, m_fare, m_km;
  bit m_dp, m_wp, m_sat, m_ovr, m_running;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_fare = 0; m_km = 0;
    m_dp = 0; m_wp = 0; m_sat = 0; m_ovr = 0; m_running = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit p,
                            input bit d, input bit w, input bit n);
    int prev;
    int charge;
    bit gd, gw;
    if (!r) begin
      model_reset();
      return;
    end
    prev = m_st;
    case (m_st)
      M_IDLE, M_HOLD: if (s) m_st = M_LOAD;
      M_LOAD: begin
        m_fare = BASE_C; m_km = 0; m_dp = 0; m_wp = 0;
        m_sat = 0; m_ovr = 0; m_st = M_RUN;
      end
      default: begin
        gd = m_dp;
        gw = m_wp && !m_dp;
        charge = 0;
        if (gd) begin
          if (m_km >= FREE_C) charge = n ? NIGHT_C : KM_C;
          if (m_km < 15) m_km++;
        end else if (gw) begin
          charge = WAIT_C;
        end
        if (charge > 0 && !m_sat) begin
          if (m_fare + charge > 9999) begin
            m_fare = 9999;
            m_sat  = 1;
          end else begin
            m_fare += charge;
          end
        end
        if (p) begin
          m_st = M_HOLD; m_dp = 0; m_wp = 0;
        end else begin
          if ((d && m_dp && !gd) || (w && m_wp && !gw)) m_ovr = 1;
          m_dp = d || (m_dp && !gd);
          m_wp = w || (m_wp && !gw);
        end
      end
    endcase
    m_running = (prev == M_LOAD) || (prev == M_RUN);
  endtask

  function automatic exp_t snapshot(input int due);
    exp_t e;
    e.due = due; e.fare = to_bcd(m_fare); e.running = m_running;
    e.sat = m_sat; e.overrun = m_ovr;
    return e;
  endfunction

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic drive(input bit s, input bit p, input bit d, input bit w);
    bit n;
    @(posedge clk); #1;
    rst_n = !hold_rst; start = s; stop = p; dist_tick = d; wait_tick = w;
`ifdef NIGHT_RATE_EN
    night = night_v;
    n = night_v;
`else
    n = 1'b0;
`endif
    model_step(rst_n, s, p, d, w, n);
    q.push_back(snapshot(cyc + 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic async_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; hold_rst = 1'b1;
    start = 0; stop = 0; dist_tick = 0; wait_tick = 0;
    while (q.size() != 0 && q[$].due >= cyc) void'(q.pop_back());
    model_reset();
    q.push_back(snapshot(cyc));
  endtask

  task automatic expect_fare(input string name, input logic [15:0] exp);
    @(negedge clk);
    check(name, fare, exp);
  endtask

  always @(negedge clk) begin
    while (q.size() != 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check("sb_fare", fare, e.fare);
      check("sb_running", 16'(running), 16'(e.running));
      check("sb_sat", 16'(sat), 16'(e.sat));
      check("sb_overrun", 16'(overrun), 16'(e.overrun));
    end
  end

  initial begin
    model_reset();
    idle(3);
    hold_rst = 1'b0;
    idle(2);

    // Trip start: flag-fall fare two cycles after the pulse.
    drive(1, 0, 0, 0);
    idle(2);
    expect_fare("start_fare", 16'h0800);
    check("start_running", 16'(running), 16'd1);
    check("start_sat", 16'(sat), 16'd0);

    // Five spaced km ticks, three of them free.
    repeat (5) begin
      drive(0, 0, 1, 0);
      idle(9);
    end
    expect_fare("five_km", 16'h1200);

    // New trip, exhaust free km, then simultaneous dist and wait.
    drive(0, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 0);
    idle(2);
    repeat (3) begin
      drive(0, 0, 1, 0);
      idle(2);
    end
    drive(0, 0, 1, 1);
    idle(2);
    expect_fare("both_dist", 16'h1000);
    idle(1);
    expect_fare("both_wait", 16'h1050);

    // Climb to 99.50, then saturate with one more km.
    repeat (44) drive(0, 0, 1, 0);
    repeat (2) drive(0, 0, 0, 1);
    idle(3);
    expect_fare("near_max", 16'h9950);
    drive(0, 0, 1, 0);
    idle(2);
    expect_fare("sat_fare", 16'h9999);
    check("sat_flag", 16'(sat), 16'd1);
    drive(0, 0, 0, 1);
    idle(2);
    expect_fare("sat_hold", 16'h9999);

    // Back-to-back km ticks are never lost; a second wait tick behind a dist grant is.
    drive(0, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 0);
    idle(2);
    repeat (3) drive(0, 0, 1, 0);
    idle(3);
    expect_fare("no_overrun", 16'h0800);
    check("no_overrun_flag", 16'(overrun), 16'd0);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);
    idle(4);
    expect_fare("overrun_fare", 16'h1250);
    check("overrun_flag", 16'(overrun), 16'd1);

    // Stop freezes the fare; start reloads; async reset clears mid-run.
    drive(0, 1, 0, 0);
    idle(2);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 1);
    idle(3);
    expect_fare("hold_frozen", 16'h1250);
    check("hold_running", 16'(running), 16'd0);
    drive(1, 0, 0, 0);
    idle(2);
    expect_fare("reload", 16'h0800);
    drive(0, 0, 0, 1);
    idle(1);
    async_reset();
    expect_fare("async_rst", 16'h0000);
    idle(2);
    hold_rst = 1'b0;
    idle(2);

`ifdef NIGHT_RATE_EN
    drive(1, 0, 0, 0);
    idle(2);
    repeat (3) begin
      drive(0, 0, 1, 0);
      idle(2);
    end
    night_v = 1'b1;
    drive(0, 0, 1, 0);
    idle(2);
    expect_fare("night_km", 16'h1100);
    night_v = 1'b0;
    drive(0, 1, 0, 0);
    idle(2);
`endif

    // Randomized trips against the model.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      night_v = ($urandom_range(1) == 1);
      drive($urandom_range(99) < 2, $urandom_range(99) < 3,
            $urandom_range(99) < 30, $urandom_range(99) < 35);
    end
    idle(3);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 16'(q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fare_accum_ctrl.md
# fare_accum_ctrl

Sequencing controller for the taxi-meter fare datapath. It owns one shared 4-digit BCD adder (`bcd_adder_4`, 16-bit sum plus carry-out) and arbitrates two requesters onto it: distance pulses and waiting-time pulses. It loads the flag-fall fare on trip start, accumulates per-km and per-wait charges, saturates at 99.99, and freezes the fare on trip stop. The display path consumes `fare` directly.

## Interface
Parameters:
- `BASE_FARE`, 16'h0800: flag-fall fare, BCD, 8.00.
- `KM_RATE`, 16'h0200: charge per distance tick, BCD, 2.00.
- `WAIT_RATE`, 16'h0050: charge per wait tick, BCD, 0.50.
- `FREE_KM`, 4'd3: number of distance ticks covered by the flag-fall fare, binary.
- `NIGHT_KM_RATE`, 16'h0300: per-km charge when `night`=1 (only with `NIGHT_RATE_EN`).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle trip-start pulse.
- `stop`  in  1  single-cycle trip-stop pulse.
- `dist_tick`  in  1  single-cycle pulse, one per km.
- `wait_tick`  in  1  single-cycle pulse, one per waiting unit.
- `night`  in  1  night-tariff select. Present only with `NIGHT_RATE_EN`.
- `fare`  out  16  BCD fare, 4 digits, 00.00–99.99.
- `running`  out  1  high in LOAD and RUN.
- `sat`  out  1  sticky; fare has saturated at 16'h9999.
- `overrun`  out  1  sticky; a tick was dropped.

## Operation
- Reset (async, `rst_n`=0): state IDLE; `fare`=0, `running`=0, `sat`=0, `overrun`=0; km counter=0; both pending flags=0.
- **States:**
  - IDLE: no arithmetic; ticks are ignored. `start` -> LOAD.
  - LOAD: `fare`<=`BASE_FARE`; km counter<=0; pending flags, `sat` and `overrun` cleared. Always -> RUN next cycle.
  - RUN: arbitration and accumulation. `stop` -> HOLD.
  - HOLD: `fare` frozen, ticks ignored. `start` -> LOAD.
- **Pending latches:** in RUN, `dist_tick` sets `dist_pend` and `wait_tick` sets `wait_pend`.
  - A tick arriving while its own flag is already set and not granted that cycle is dropped and sets `overrun`.
- **Arbitration:** at most one addition per cycle. Fixed priority: `dist_pend` over `wait_pend`. The ungranted request stays pending.
  - A tick and a grant of the same type in the same cycle re-set the flag; nothing is lost.
- **Distance grant:**
  - km counter increments, saturating at 15.
  - If the pre-increment count is below `FREE_KM`, the flag is cleared with no addition.
  - Otherwise the adder operand b is the km rate.
- **Wait grant:** b=`WAIT_RATE`.
- **Adder hookup:** a=`fare`, c_in=0.
  - If c_out=0: `fare`<=sum.
  - If c_out=1: `fare`<=16'h9999 and `sat`<=1.
  - Once `sat`=1, further grants consume their requests without changing `fare`.
- **Simultaneous controls:** `start` and `stop` in the same cycle: `start` wins in IDLE/HOLD; `stop` wins in RUN. In LOAD, `stop` is ignored.
- **Ticks in the `stop` cycle:** a tick in the same cycle as `stop` in RUN is discarded. Pending flags are dropped on entering HOLD.

## Timing
- `start` at cycle N: state=LOAD at N+1; `fare`=`BASE_FARE` and state=RUN at N+2.
- Tick at cycle N in RUN (no contention): flag set at N+1; grant at N+1; `fare` updated at N+2. Latency is 2 clocks.
- Both ticks at N: dist applied at N+2, wait applied at N+3.
- `running` is registered and follows the state one cycle after each transition edge.
- Adder path is combinational within one cycle; no multicycle paths.

## Configuration
- `NIGHT_RATE_EN` defined:
  - `night` port and `NIGHT_KM_RATE` are present.
  - The km operand is `NIGHT_KM_RATE` when `night`=1, sampled in the grant cycle.
- `NIGHT_RATE_EN` undefined:
  - `night` port is absent.
  - The km operand is always `KM_RATE`.

## Structure
- Shared package `fare_pkg`: state encoding (IDLE, LOAD, RUN, HOLD) and the BCD constant 16'h9999 (FARE_MAX).
- Sub-module: one instance of the existing `bcd_adder_4`. All other logic is in `fare_accum_ctrl`.

## Test plan
- Reset then `start`: `fare`=16'h0800 two cycles after the pulse; `running`=1; `sat`=0.
- 5 `dist_tick` pulses, 10 cycles apart, defaults: first 3 are free; `fare`=16'h1200.
- `dist_tick` and `wait_tick` in the same cycle from 08.00 after free km exhausted: `fare`=16'h1000 at N+2, then 16'h1050 at N+3.
- Preload near max (many wait ticks) to 99.50, then one `dist_tick` (rate 2.00): `fare`=16'h9999, `sat`=1. A further tick leaves `fare` at 9999.
- `dist_tick` on 3 consecutive cycles while `wait_pend` is not set: no overrun, all 3 accumulated. Forcing a second `wait_tick` while `wait_pend` is held by a dist grant sets `overrun`=1.
- `stop` mid-trip then ticks: `fare` unchanged. `start` reloads 16'h0800. `rst_n`=0 mid-RUN clears `fare` to 0 asynchronously.
- With `NIGHT_RATE_EN`, `night`=1, 4th `dist_tick` from 08.00: `fare`=16'h1100.
